div_pipe_ctrl: RTL and testbench

- Issue/retire controller that shares one pipelined radix-4 significand divider datapath (div_sigcalc) among N_REQ requesters.
- Arbitrates requests round-robin and steers the winner's operands into the datapath.
- Drives the datapath's global enable (stall), tracks in-flight ops with a valid/owner/tag shadow pipeline, and routes each result back to its owner with valid/ready backpressure.
- Sits between FP-divide front-ends (sign/exponent units) and div_sigcalc.

---
 rtl/div_ctrl_pkg.sv | 27 ++
 rtl/div_pipe_ctrl_rr_arbiter.sv | 49 ++++
 rtl/div_pipe_ctrl.sv | 140 ++++++++++++++
 tb/tb_div_pipe_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared types and helpers for the divider issue/retire controller.
package div_ctrl_pkg;

  // Owner index width covers up to four requesters.
  localparam int OWNER_W  = 2;
  // Tag width carried through the shadow pipe.
  localparam int SH_TAG_W = 4;

  typedef struct packed {
    logic count;
    logic guard;
    logic round;
    logic sticky;
  } div_flags_t;

  typedef struct packed {
    logic                v;
    logic [OWNER_W-1:0]  owner;
    logic [SH_TAG_W-1:0] tag;
  } shadow_entry_t;

  // Number of datapath registers between operand input and quotient output.
  function automatic int pipe_lat(input int pipe_stages);
    return pipe_stages;
  endfunction

endpackage

// File: rtl/div_pipe_ctrl_rr_arbiter.sv
// Round-robin arbiter: search starts at rr_ptr, pointer moves past the winner on advance.
module rr_arbiter
  import div_ctrl_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               clear,
  input  logic [N_REQ-1:0]   req,
  input  logic               advance,
  output logic [N_REQ-1:0]   grant,
  output logic [OWNER_W-1:0] winner,
  output logic               found
);

  logic [OWNER_W-1:0] rr_ptr;

  // First pass takes requesters at or above the pointer, second pass wraps around.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    grant  = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && req[j] && (OWNER_W'(j) >= rr_ptr)) begin
        found    = 1'b1;
        winner   = OWNER_W'(j);
        grant[j] = 1'b1;
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && req[j]) begin
        found    = 1'b1;
        winner   = OWNER_W'(j);
        grant[j] = 1'b1;
      end
    end
  end

  // Pointer advances to winner+1 (mod N_REQ) only when the grant is taken.
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (winner == OWNER_W'(N_REQ - 1)) ? '0 : winner + OWNER_W'(1);
    end
  end

endmodule

// File: rtl/div_pipe_ctrl.sv
// Issue/retire controller sharing one pipelined significand divider among requesters.
// A shadow pipe of {v, owner, tag} runs alongside the datapath registers so each
// quotient can be routed back to its owner; the whole pipe stalls on result backpressure.
module div_pipe_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int SIG_W       = 23,
  parameter int PIPE_STAGES = 3,
  parameter int N_REQ       = 2,
  parameter int TAG_W       = SH_TAG_W
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*(SIG_W+1)-1:0]   req_x,
  input  logic [N_REQ*(SIG_W+1)-1:0]   req_d,
  input  logic [N_REQ*TAG_W-1:0]       req_tag,
  output logic [SIG_W:0]               dp_x,
  output logic [SIG_W:0]               dp_d,
  output logic                         dp_enable,
  input  logic [SIG_W:0]               dp_quotient,
  input  logic [3:0]                   dp_flags,
  output logic [N_REQ-1:0]             res_valid,
  input  logic [N_REQ-1:0]             res_ready,
  output logic [SIG_W:0]               res_quotient,
  output logic [3:0]                   res_flags,
  output logic [TAG_W-1:0]             res_tag,
  output logic                         idle,
  output logic [$clog2(pipe_lat(PIPE_STAGES)+2)-1:0] inflight
);

  localparam int LAT   = pipe_lat(PIPE_STAGES);
  localparam int CNT_W = $clog2(LAT + 2);
  localparam int OP_W  = SIG_W + 1;

  logic [N_REQ-1:0]   arb_grant;
  logic [OWNER_W-1:0] win;
  logic               found;
  logic               issue;
  logic               stall;
  logic               head_v;
  logic               out_v;
  logic [OWNER_W-1:0] out_owner;
  logic [TAG_W-1:0]   out_tag;
  logic [TAG_W-1:0]   win_tag;
  logic               sel_ready;
  div_flags_t         res_fl;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (flush),
    .req     (req_valid),
    .advance (issue),
    .grant   (arb_grant),
    .winner  (win),
    .found   (found)
  );

  // Steer the winner's operands; requester 0 when nobody is asking.
  always_comb begin
    dp_x    = req_x[OP_W-1:0];
    dp_d    = req_d[OP_W-1:0];
    win_tag = req_tag[TAG_W-1:0];
    for (int j = 0; j < N_REQ; j++) begin
      if (win == OWNER_W'(j)) begin
        dp_x    = req_x[j*OP_W +: OP_W];
        dp_d    = req_d[j*OP_W +: OP_W];
        win_tag = req_tag[j*TAG_W +: TAG_W];
      end
    end
  end

  // Ready of whichever requester owns the op at the datapath output.
  always_comb begin
    sel_ready = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (out_owner == OWNER_W'(j)) sel_ready = res_ready[j];
    end
  end

  // Stall when the result at the output cannot be delivered; flush and reset force the pipe to move.
  assign stall     = head_v & ~sel_ready;
  assign issue     = found & ~stall & ~flush & resetn;
  assign dp_enable = ~stall | flush | ~resetn;
  assign req_ready = issue ? arb_grant : '0;

  // One-hot result valid toward the owner of the output op.
  always_comb begin
    res_valid = '0;
    for (int j = 0; j < N_REQ; j++) begin
      res_valid[j] = out_v & ~flush & resetn & (out_owner == OWNER_W'(j));
    end
  end

  assign res_fl       = dp_flags;
  assign res_flags    = res_fl;
  assign res_quotient = dp_quotient;
  assign res_tag      = out_tag;
  assign idle         = (inflight == '0);

  if (LAT == 0) begin : g_comb
    // Combinational datapath: the issuing op is the retiring op.
    assign head_v    = found;
    assign out_v     = issue;
    assign out_owner = win;
    assign out_tag   = win_tag;
    assign inflight  = '0;
  end else begin : g_pipe
    shadow_entry_t       sh [LAT];
    shadow_entry_t       new_e;
    logic [CNT_W-1:0]    cnt;

    assign new_e     = '{v: issue, owner: win, tag: SH_TAG_W'(win_tag)};
    assign head_v    = sh[LAT-1].v;
    assign out_v     = sh[LAT-1].v;
    assign out_owner = sh[LAT-1].owner;
    assign out_tag   = sh[LAT-1].tag[TAG_W-1:0];
    assign inflight  = cnt;

    // Shadow pipe shifts in lockstep with the datapath enable; reset/flush drop every op.
    always_ff @(posedge clk) begin
      if (!resetn || flush) begin
        for (int k = 0; k < LAT; k++) sh[k].v <= 1'b0;
      end else if (dp_enable) begin
        sh[0] <= new_e;
        for (int k = 1; k < LAT; k++) sh[k] <= sh[k-1];
      end
    end

    // Count valid ops in flight.
    always_comb begin
      cnt = '0;
      for (int k = 0; k < LAT; k++) cnt = cnt + CNT_W'(sh[k].v);
    end
  end

endmodule

// File: tb/tb_div_pipe_ctrl.sv
// Bench for div_pipe_ctrl: a 3-stage instance with a scoreboard model and directed
// corner sequences, plus a combinational (0-stage) instance driven from a vector table.
module tb_div_pipe_ctrl;

  localparam int OP_W = 24;
  localparam int N    = 2;
  localparam int TW   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [23:0] calc_q(input logic [23:0] x, input logic [23:0] d);
    logic [46:0] n;
    if (d == 24'd0) return 24'd0;
    n = {x, 23'd0};
    return 24'(n / {23'd0, d});
  endfunction

  function automatic logic [3:0] calc_f(input logic [23:0] x, input logic [23:0] d);
    return x[3:0] ^ d[3:0];
  endfunction

  // ---------------- DUT A: three datapath stages ----------------
  logic              resetn_a, flush_a;
  logic [N-1:0]      req_valid_a, req_ready_a, res_valid_a, res_ready_a;
  logic [N*OP_W-1:0] req_x_a, req_d_a;
  logic [N*TW-1:0]   req_tag_a;
  logic [23:0]       dp_x_a, dp_d_a, dp_q_a, res_q_a;
  logic              dp_en_a, idle_a;
  logic [3:0]        dp_f_a, res_f_a, res_tag_a;
  logic [2:0]        infl_a;

  div_pipe_ctrl #(.SIG_W(23), .PIPE_STAGES(3), .N_REQ(N), .TAG_W(TW)) dut_a (
    .clk(clk), .resetn(resetn_a), .flush(flush_a),
    .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_x(req_x_a), .req_d(req_d_a), .req_tag(req_tag_a),
    .dp_x(dp_x_a), .dp_d(dp_d_a), .dp_enable(dp_en_a),
    .dp_quotient(dp_q_a), .dp_flags(dp_f_a),
    .res_valid(res_valid_a), .res_ready(res_ready_a),
    .res_quotient(res_q_a), .res_flags(res_f_a), .res_tag(res_tag_a),
    .idle(idle_a), .inflight(infl_a)
  );

  // Stand-in datapath: three enabled operand registers, quotient computed at the end.
  logic [23:0] px [3] = '{default: 24'h800000};
  logic [23:0] pd [3] = '{default: 24'h800000};
  always @(posedge clk) begin
    if (dp_en_a) begin
      px[0] <= dp_x_a; pd[0] <= dp_d_a;
      px[1] <= px[0];  pd[1] <= pd[0];
      px[2] <= px[1];  pd[2] <= pd[1];
    end
  end
  assign dp_q_a = calc_q(px[2], pd[2]);
  assign dp_f_a = calc_f(px[2], pd[2]);

  // ---------------- DUT B: combinational datapath ----------------
  logic              resetn_b, flush_b;
  logic [N-1:0]      req_valid_b, req_ready_b, res_valid_b, res_ready_b;
  logic [N*OP_W-1:0] req_x_b, req_d_b;
  logic [N*TW-1:0]   req_tag_b;
  logic [23:0]       dp_x_b, dp_d_b, dp_q_b, res_q_b;
  logic              dp_en_b, idle_b;
  logic [3:0]        dp_f_b, res_f_b, res_tag_b;
  logic [0:0]        infl_b;

  div_pipe_ctrl #(.SIG_W(23), .PIPE_STAGES(0), .N_REQ(N), .TAG_W(TW)) dut_b (
    .clk(clk), .resetn(resetn_b), .flush(flush_b),
    .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_x(req_x_b), .req_d(req_d_b), .req_tag(req_tag_b),
    .dp_x(dp_x_b), .dp_d(dp_d_b), .dp_enable(dp_en_b),
    .dp_quotient(dp_q_b), .dp_flags(dp_f_b),
    .res_valid(res_valid_b), .res_ready(res_ready_b),
    .res_quotient(res_q_b), .res_flags(res_f_b), .res_tag(res_tag_b),
    .idle(idle_b), .inflight(infl_b)
  );
  assign dp_q_b = calc_q(dp_x_b, dp_d_b);
  assign dp_f_b = calc_f(dp_x_b, dp_d_b);

  // ---------------- Reference model for DUT A ----------------
  // Ops are kept in issue order with a count of enabled clock edges since issue;
  // an op is presented once it has seen three enabled edges.
  typedef struct {
    int          owner;
    logic [3:0]  tag;
    logic [23:0] x;
    logic [23:0] d;
    int          age;
  } op_t;

  op_t  q[$];
  int   ptr_m = 0;
  bit   mon_en = 0;
  bit   s_valid = 0;
  bit   s_issue, s_retire, s_en, s_clear;
  int   s_win;
  logic [3:0]  s_tag;
  logic [23:0] s_x, s_d;
  bit   m_head, m_stall, m_issue;
  int   m_w, m_c;
  logic [1:0] m_exp_rr, m_exp_rv;

  always @(negedge clk) begin
    if (mon_en) begin
      m_head  = (q.size() > 0) && (q[0].age == 3);
      m_stall = m_head && res_ready_a[q[0].owner];
      m_stall = m_head && !m_stall;
      m_w = -1;
      for (int i = 0; i < N; i++) begin
        m_c = (ptr_m + i) % N;
        if (m_w < 0 && req_valid_a[m_c]) m_w = m_c;
      end
      m_issue  = resetn_a && !flush_a && (m_w >= 0) && !m_stall;
      m_exp_rr = m_issue ? 2'(1 << m_w) : 2'b00;
      m_exp_rv = (m_head && resetn_a && !flush_a) ? 2'(1 << q[0].owner) : 2'b00;
      chk("a_req_ready", 64'(req_ready_a), 64'(m_exp_rr));
      chk("a_res_valid", 64'(res_valid_a), 64'(m_exp_rv));
      chk("a_dp_enable", 64'(dp_en_a), 64'(!m_stall || flush_a || !resetn_a));
      chk("a_inflight", 64'(infl_a), 64'(q.size()));
      chk("a_idle", 64'(idle_a), 64'(q.size() == 0));
      if (m_exp_rv != 2'b00) begin
        chk("a_res_tag", 64'(res_tag_a), 64'(q[0].tag));
        chk("a_res_quotient", 64'(res_q_a), 64'(calc_q(q[0].x, q[0].d)));
        chk("a_res_flags", 64'(res_f_a), 64'(calc_f(q[0].x, q[0].d)));
      end
      s_issue  = m_issue;
      s_retire = m_head && !m_stall && resetn_a && !flush_a;
      s_en     = !m_stall;
      s_clear  = !resetn_a || flush_a;
      s_win    = m_w;
      if (m_w >= 0) begin
        s_tag = req_tag_a[m_w*TW +: TW];
        s_x   = req_x_a[m_w*OP_W +: OP_W];
        s_d   = req_d_a[m_w*OP_W +: OP_W];
        if (m_issue) chk("a_dp_x", 64'(dp_x_a), 64'(s_x));
      end
      s_valid = 1;
    end
  end

  always @(posedge clk) begin
    if (mon_en && s_valid) begin
      if (s_clear) begin
        q.delete();
        ptr_m = 0;
      end else begin
        if (s_retire) void'(q.pop_front());
        if (s_issue) begin
          q.push_back('{owner: s_win, tag: s_tag, x: s_x, d: s_d, age: 0});
          ptr_m = (s_win + 1) % N;
        end
        if (s_en) foreach (q[i]) q[i].age = q[i].age + 1;
      end
    end
  end

  task automatic set_op_a(input int r, input logic [23:0] x, input logic [23:0] d, input logic [3:0] t);
    req_x_a[r*OP_W +: OP_W] = x;
    req_d_a[r*OP_W +: OP_W] = d;
    req_tag_a[r*TW +: TW]   = t;
  endtask

  // ---------------- Vector table for DUT B ----------------
  typedef struct {
    logic [1:0] rv;
    logic [1:0] rr;
    logic [1:0] exp_ready;
    logic [1:0] exp_res;
  } vec_t;
  vec_t tv [10];

  logic [1:0]  gr [9];
  logic [1:0]  rvs [9];
  logic [23:0] held_q;

  initial begin
    tv[0] = '{2'b01, 2'b00, 2'b00, 2'b00};
    tv[1] = '{2'b10, 2'b00, 2'b00, 2'b00};
    tv[2] = '{2'b10, 2'b10, 2'b10, 2'b10};
    tv[3] = '{2'b11, 2'b11, 2'b01, 2'b01};
    tv[4] = '{2'b11, 2'b11, 2'b10, 2'b10};
    tv[5] = '{2'b11, 2'b10, 2'b00, 2'b00};
    tv[6] = '{2'b11, 2'b01, 2'b01, 2'b01};
    tv[7] = '{2'b11, 2'b01, 2'b00, 2'b00};
    tv[8] = '{2'b00, 2'b11, 2'b00, 2'b00};
    tv[9] = '{2'b10, 2'b11, 2'b10, 2'b10};

    resetn_a = 0; flush_a = 0; req_valid_a = '0; res_ready_a = 2'b11;
    req_x_a = {2{24'h800000}}; req_d_a = {2{24'h800000}}; req_tag_a = '0;
    resetn_b = 0; flush_b = 0; req_valid_b = '0; res_ready_b = '0;
    req_x_b = {24'h900000, 24'hC00000};
    req_d_b = {24'hC00000, 24'h800000};
    req_tag_b = {4'd9, 4'd3};

    repeat (2) @(posedge clk);
    #1 resetn_a = 1; resetn_b = 1; mon_en = 1;
    @(negedge clk);
    chk("reset_idle", 64'(idle_a), 64'd1);
    chk("reset_res_valid", 64'(res_valid_a), 64'd0);
    chk("reset_b_res_valid", 64'(res_valid_b), 64'd0);

    // Single op: result exactly three cycles after issue.
    @(posedge clk); #1;
    set_op_a(0, 24'hC00000, 24'h800000, 4'd5);
    req_valid_a = 2'b01;
    @(negedge clk); chk("t1_ready", 64'(req_ready_a), 64'h1);
    @(posedge clk); #1 req_valid_a = '0;
    @(negedge clk); chk("t1_no_res_c1", 64'(res_valid_a), 64'h0);
    @(negedge clk); chk("t1_no_res_c2", 64'(res_valid_a), 64'h0);
    @(negedge clk);
    chk("t1_res_valid", 64'(res_valid_a), 64'h1);
    chk("t1_quotient", 64'(res_q_a), 64'hC00000);
    chk("t1_tag", 64'(res_tag_a), 64'h5);
    @(negedge clk); chk("t1_idle", 64'(idle_a), 64'h1);

    // Round-robin alternation and in-order return; flush first to reset the pointer.
    @(posedge clk); #1 flush_a = 1;
    @(posedge clk); #1 flush_a = 0;
    set_op_a(0, 24'hA00000, 24'h800000, 4'd1);
    set_op_a(1, 24'hB00000, 24'hC00000, 4'd2);
    req_valid_a = 2'b11; res_ready_a = 2'b11;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      gr[i]  = req_ready_a;
      rvs[i] = res_valid_a;
      if (i == 5) begin @(posedge clk); #1 req_valid_a = '0; end
    end
    for (int i = 0; i < 6; i++) chk("t2_grant", 64'(gr[i]), (i % 2) ? 64'h2 : 64'h1);
    for (int i = 0; i < 3; i++) chk("t2_no_early_res", 64'(rvs[i]), 64'h0);
    for (int i = 3; i < 9; i++) chk("t2_res_order", 64'(rvs[i]), ((i - 3) % 2) ? 64'h2 : 64'h1);

    // Backpressure: owner-1 result held for four cycles, then retire with a new issue.
    @(posedge clk); #1;
    set_op_a(1, 24'hA00000, 24'hC00000, 4'd7);
    req_valid_a = 2'b10; res_ready_a = 2'b01;
    @(negedge clk); chk("t3_issue1", 64'(req_ready_a), 64'h2);
    @(posedge clk); #1 req_valid_a = 2'b01;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) held_q = res_q_a;
      chk("t3_dp_enable", 64'(dp_en_a), 64'h0);
      chk("t3_req_ready", 64'(req_ready_a), 64'h0);
      chk("t3_res_valid", 64'(res_valid_a), 64'h2);
      chk("t3_held_quotient", 64'(res_q_a), 64'(held_q));
    end
    chk("t3_quotient", 64'(held_q), 64'(calc_q(24'hA00000, 24'hC00000)));
    @(posedge clk); #1 res_ready_a = 2'b11;
    @(negedge clk);
    chk("t3_retire", 64'(res_valid_a), 64'h2);
    chk("t3_new_issue", 64'(req_ready_a), 64'h1);
    chk("t3_enable", 64'(dp_en_a), 64'h1);
    @(posedge clk); #1 req_valid_a = '0;
    repeat (5) @(posedge clk);

    // Flush with three ops in flight.
    #1 req_valid_a = 2'b01;
    repeat (3) @(posedge clk);
    #1 req_valid_a = 2'b11; flush_a = 1;
    @(negedge clk);
    chk("t4_inflight_before", 64'(infl_a), 64'h3);
    chk("t4_res_valid", 64'(res_valid_a), 64'h0);
    chk("t4_req_ready", 64'(req_ready_a), 64'h0);
    chk("t4_dp_enable", 64'(dp_en_a), 64'h1);
    @(posedge clk); #1 flush_a = 0; req_valid_a = '0;
    @(negedge clk); chk("t4_inflight_after", 64'(infl_a), 64'h0);
    for (int i = 0; i < 3; i++) begin
      chk("t4_no_res", 64'(res_valid_a), 64'h0);
      @(negedge clk);
    end
    @(posedge clk); #1 req_valid_a = 2'b11;
    @(negedge clk); chk("t4_ptr_reset", 64'(req_ready_a), 64'h1);
    @(posedge clk); #1 req_valid_a = '0;
    repeat (5) @(posedge clk);

    // Reset with two ops in flight.
    #1 req_valid_a = 2'b11;
    @(posedge clk); #1;
    @(posedge clk); #1 resetn_a = 0;
    @(negedge clk);
    chk("t5_res_valid", 64'(res_valid_a), 64'h0);
    chk("t5_req_ready", 64'(req_ready_a), 64'h0);
    chk("t5_dp_enable", 64'(dp_en_a), 64'h1);
    @(posedge clk); #1 resetn_a = 1; req_valid_a = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_after_res_valid", 64'(res_valid_a), 64'h0);
      chk("t5_after_idle", 64'(idle_a), 64'h1);
    end

    // Random traffic against the scoreboard.
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      req_valid_a = 2'($urandom);
      res_ready_a = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b11;
      flush_a     = ($urandom_range(0, 49) == 0);
      for (int r = 0; r < N; r++)
        set_op_a(r, 24'h800000 | 24'($urandom), 24'h800000 | 24'($urandom), 4'($urandom));
    end
    @(posedge clk); #1 req_valid_a = '0; res_ready_a = 2'b11; flush_a = 0;
    repeat (6) @(posedge clk);

    // Zero-latency instance from the vector table.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      req_valid_b = tv[i].rv;
      res_ready_b = tv[i].rr;
      @(negedge clk);
      chk($sformatf("b_req_ready[%0d]", i), 64'(req_ready_b), 64'(tv[i].exp_ready));
      chk($sformatf("b_res_valid[%0d]", i), 64'(res_valid_b), 64'(tv[i].exp_res));
      if (tv[i].exp_res == 2'b01) begin
        chk("b_tag0", 64'(res_tag_b), 64'h3);
        chk("b_q0", 64'(res_q_b), 64'hC00000);
      end else if (tv[i].exp_res == 2'b10) begin
        chk("b_tag1", 64'(res_tag_b), 64'h9);
        chk("b_q1", 64'(res_q_b), 64'h600000);
      end
      chk("b_idle", 64'(idle_b), 64'h1);
    end
    @(posedge clk); #1 req_valid_b = '0;
    mon_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
